// File: rtl/types_pkg.sv
// ---------------------------------------------------------------------------
// types_pkg
// Shared types for the RV32M multiply/divide unit.
//   XLEN            : default operand/result width
//   FUNCT7_MULDIV   : funct7 encoding of the M-extension instructions
//   muldiv_op_e     : funct3 selector (MUL..REMU)
//   muldiv_state_e  : sequencer states of muldiv_unit
// ---------------------------------------------------------------------------
package types_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] FUNCT7_MULDIV = 7'b000_0001;

   typedef enum logic [2:0] {
      F3_MUL    = 3'b000,
      F3_MULH   = 3'b001,
      F3_MULHSU = 3'b010,
      F3_MULHU  = 3'b011,
      F3_DIV    = 3'b100,
      F3_DIVU   = 3'b101,
      F3_REM    = 3'b110,
      F3_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      FINISH = 2'd2
   } muldiv_state_e;

endpackage

// File: rtl/muldiv_operand_prep.sv
// ---------------------------------------------------------------------------
// muldiv_operand_prep
// Combinational operand conditioning: decides which operands are signed for
// the requested op, captures their signs and produces magnitudes so that the
// iterative datapath only ever works on unsigned values.
//   op           : funct3 of the operation
//   a, b         : raw rs1 / rs2 operands
//   a_neg, b_neg : operand is treated as signed and is negative
//   a_abs, b_abs : magnitudes (the most-negative value maps to 2**(XLEN-1))
// ---------------------------------------------------------------------------
module muldiv_operand_prep
   import types_pkg::*;
#(
   parameter int XLEN = types_pkg::XLEN
) (
   input  muldiv_op_e        op,
   input  logic [XLEN-1:0]   a,
   input  logic [XLEN-1:0]   b,
   output logic              a_neg,
   output logic              b_neg,
   output logic [XLEN-1:0]   a_abs,
   output logic [XLEN-1:0]   b_abs
);

   logic a_signed;
   logic b_signed;

   always_comb begin
      // MUL only needs the low half, which is sign-agnostic, so it runs unsigned
      a_signed = (op == F3_MULH) || (op == F3_MULHSU) || (op == F3_DIV) || (op == F3_REM);
      b_signed = (op == F3_MULH) || (op == F3_DIV) || (op == F3_REM);
      a_neg    = a_signed && a[XLEN-1];
      b_neg    = b_signed && b[XLEN-1];
      a_abs    = a_neg ? (-a) : a;
      b_abs    = b_neg ? (-b) : b;
   end

endmodule

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, one step per cycle for XLEN cycles,
// signs and special cases resolved in FINISH.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request an operation (accepted only in IDLE)
//   op, a, b   : funct3 and operands, latched when start is accepted
//   flush      : abort, returns to IDLE on the next edge (beats start)
//   busy       : high in CALC and FINISH
//   done       : one-cycle completion pulse (in FINISH)
//   result     : valid with done, held afterwards
// Build option: define MULDIV_EARLY_TERM_EN to let divide-by-zero, signed
// overflow and multiply-by-zero skip CALC and finish one cycle after start.
// ---------------------------------------------------------------------------
module muldiv_unit
   import types_pkg::*;
#(
   parameter int XLEN = types_pkg::XLEN
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  muldiv_op_e        op,
   input  logic [XLEN-1:0]   a,
   input  logic [XLEN-1:0]   b,
   input  logic              flush,
   output logic              busy,
   output logic              done,
   output logic [XLEN-1:0]   result
);

   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
`ifdef MULDIV_EARLY_TERM_EN
   localparam bit EARLY_TERM = 1'b1;
`else
   localparam bit EARLY_TERM = 1'b0;
`endif

   function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
      return neg ? (-v) : v;
   endfunction

   function automatic logic [2*XLEN-1:0] cond_neg_w(input logic neg, input logic [2*XLEN-1:0] v);
      return neg ? (-v) : v;
   endfunction

   muldiv_state_e     state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   muldiv_op_e        op_q, op_d;
   logic [XLEN-1:0]   a_q, a_d;
   logic [XLEN-1:0]   hi_q, hi_d;     // product high half / partial remainder
   logic [XLEN-1:0]   lo_q, lo_d;     // multiplier -> product low half / dividend -> quotient
   logic [XLEN-1:0]   md_q, md_d;     // multiplicand or divisor magnitude
   logic              neg_q, neg_d;
   logic              rem_neg_q, rem_neg_d;
   logic              div0_q, div0_d;
   logic              ovf_q, ovf_d;
   logic              mzero_q, mzero_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic              a_neg, b_neg;
   logic [XLEN-1:0]   a_abs, b_abs;
   logic              is_div_in, div0_in, ovf_in, mzero_in, skip_in;
   logic [XLEN:0]     mul_sum, div_shift, div_diff;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   final_res;

   muldiv_operand_prep #(.XLEN(XLEN)) u_prep (
      .op    (op),
      .a     (a),
      .b     (b),
      .a_neg (a_neg),
      .b_neg (b_neg),
      .a_abs (a_abs),
      .b_abs (b_abs)
   );

   always_comb begin
      is_div_in = op[2];
      div0_in   = is_div_in && (b == '0);
      ovf_in    = ((op == F3_DIV) || (op == F3_REM)) && (a == MOST_NEG) && (b == '1);
      mzero_in  = !is_div_in && ((a == '0) || (b == '0));
      skip_in   = EARLY_TERM && (div0_in || ovf_in || mzero_in);
   end

   // one radix-2 step of each algorithm, plus final sign/special-case fix-up
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, md_q} : '0);
      div_shift = {hi_q, lo_q[XLEN-1]};
      // bit XLEN of the difference is the borrow: set means "do not subtract"
      div_diff  = div_shift - {1'b0, md_q};
      prod_fix  = cond_neg_w(neg_q, {hi_q, lo_q});
      case (op_q)
         F3_MUL:                       final_res = prod_fix[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:              final_res = div0_q ? '1 : (ovf_q ? a_q : cond_neg(neg_q, lo_q));
         default:                      final_res = div0_q ? a_q : (ovf_q ? '0 : cond_neg(rem_neg_q, hi_q));
      endcase
      // multiply by zero may have skipped CALC, leaving the registers unprimed
      if (mzero_q) final_res = '0;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      a_d       = a_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      md_d      = md_q;
      neg_d     = neg_q;
      rem_neg_d = rem_neg_q;
      div0_d    = div0_q;
      ovf_d     = ovf_q;
      mzero_d   = mzero_q;
      result_d  = result_q;
      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_d   = skip_in ? FINISH : CALC;
                  cnt_d     = skip_in ? '0 : CW'(XLEN);
                  op_d      = op;
                  a_d       = a;
                  hi_d      = '0;
                  lo_d      = is_div_in ? a_abs : b_abs;
                  md_d      = is_div_in ? b_abs : a_abs;
                  neg_d     = a_neg ^ b_neg;
                  rem_neg_d = a_neg;
                  div0_d    = div0_in;
                  ovf_d     = ovf_in;
                  mzero_d   = mzero_in;
               end
            end
            CALC: begin
               cnt_d = cnt_q - CW'(1);
               if (op_q[2]) begin
                  if (!div_diff[XLEN]) begin
                     hi_d = div_diff[XLEN-1:0];
                     lo_d = {lo_q[XLEN-2:0], 1'b1};
                  end else begin
                     hi_d = div_shift[XLEN-1:0];
                     lo_d = {lo_q[XLEN-2:0], 1'b0};
                  end
               end else begin
                  hi_d = mul_sum[XLEN:1];
                  lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
               end
               if (cnt_d == '0) state_d = FINISH;
            end
            FINISH: begin
               state_d  = IDLE;
               result_d = final_res;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         op_q      <= F3_MUL;
         a_q       <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         md_q      <= '0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         div0_q    <= 1'b0;
         ovf_q     <= 1'b0;
         mzero_q   <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         a_q       <= a_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         md_q      <= md_d;
         neg_q     <= neg_d;
         rem_neg_q <= rem_neg_d;
         div0_q    <= div0_d;
         ovf_q     <= ovf_d;
         mzero_q   <= mzero_d;
         result_q  <= result_d;
      end
   end

   always_comb begin
      busy   = (state_q != IDLE);
      done   = (state_q == FINISH) && !flush;
      result = done ? final_res : result_q;
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit (XLEN=32): directed vector table,
// hand-written abort/reset/back-to-back sequences and randomized operations
// against a 64-bit arithmetic reference model.
// Honours MULDIV_EARLY_TERM_EN for the expected latency.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;
   import types_pkg::*;

`ifdef MULDIV_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        start;
   muldiv_op_e  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int total;
   int bad;

   typedef struct {
      muldiv_op_e  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[18];

   muldiv_unit #(.XLEN(32)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .flush  (flush),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: plain 64-bit arithmetic on sign/zero-extended operands
   function automatic logic [31:0] model(input muldiv_op_e o, input logic [31:0] x, input logic [31:0] y);
      logic signed [63:0] sx, sy, uy_s, p;
      logic [63:0]        ux, uy, up;
      sx   = {{32{x[31]}}, x};
      sy   = {{32{y[31]}}, y};
      ux   = {32'd0, x};
      uy   = {32'd0, y};
      uy_s = $signed(uy);
      case (o)
         F3_MUL:    begin p = sx * sy;   return p[31:0];  end
         F3_MULH:   begin p = sx * sy;   return p[63:32]; end
         F3_MULHSU: begin p = sx * uy_s; return p[63:32]; end
         F3_MULHU:  begin up = ux * uy;  return up[63:32]; end
         F3_DIV: begin
            if (y == 32'd0) return 32'hFFFF_FFFF;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
            p = sx / sy;
            return p[31:0];
         end
         F3_REM: begin
            if (y == 32'd0) return x;
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
            p = sx % sy;
            return p[31:0];
         end
         F3_DIVU: begin
            if (y == 32'd0) return 32'hFFFF_FFFF;
            return x / y;
         end
         default: begin
            if (y == 32'd0) return x;
            return x % y;
         end
      endcase
   endfunction

   function automatic int exp_lat(input muldiv_op_e o, input logic [31:0] x, input logic [31:0] y);
      logic special;
      if (o inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU})
         special = (y == 32'd0) ||
                   ((o == F3_DIV || o == F3_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
      else
         special = (x == 32'd0) || (y == 32'd0);
      return (EARLY && special) ? 1 : 33;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(1, 15));
         default: return $urandom();
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   // Caller is at a negedge; start is presented for one cycle (cycle N).
   // Returns at the negedge of the cycle in which done was seen.
   task automatic do_op(input muldiv_op_e o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input string name);
      int k;
      int gaps;
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      k    = 0;
      gaps = 0;
      do begin
         @(negedge clk);
         k++;
         if (!busy) gaps++;
      end while (!done && k < 100);
      check({name, " latency"}, 32'(k), 32'(exp_lat(o, x, y)));
      check({name, " result"}, result, exp);
      check({name, " busy_gaps"}, 32'(gaps), 32'd0);
   endtask

   initial begin
      int k;
      int first;
      int ndone;
      logic [31:0] held;

      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      start = 1'b0;
      flush = 1'b0;
      op    = F3_MUL;
      a     = '0;
      b     = '0;

      vecs[0]  = '{F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
      vecs[1]  = '{F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[2]  = '{F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000};
      vecs[3]  = '{F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF};
      vecs[4]  = '{F3_DIV,    32'hFFFF_FFEC,  32'd6,         32'hFFFF_FFFD};
      vecs[5]  = '{F3_REM,    32'hFFFF_FFEC,  32'd6,         32'hFFFF_FFFE};
      vecs[6]  = '{F3_DIVU,   32'd20,         32'd0,         32'hFFFF_FFFF};
      vecs[7]  = '{F3_REMU,   32'd20,         32'd0,         32'd20};
      vecs[8]  = '{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
      vecs[9]  = '{F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000};
      vecs[10] = '{F3_MUL,    32'd0,          32'd5,         32'd0};
      vecs[11] = '{F3_MULHU,  32'd5,          32'd0,         32'd0};
      vecs[12] = '{F3_DIV,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF};
      vecs[13] = '{F3_REM,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9};
      vecs[14] = '{F3_REM,    32'd7,          32'hFFFF_FFFE, 32'd1};
      vecs[15] = '{F3_DIVU,   32'h8000_0000,  32'd3,         32'h2AAA_AAAA};
      vecs[16] = '{F3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
      vecs[17] = '{F3_MULHSU, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset result", result, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);

      // directed table, with done width and result hold after each
      for (int i = 0; i < 18; i++) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
         @(negedge clk);
         check($sformatf("vec%0d done_width", i), 32'(done), 32'd0);
         check($sformatf("vec%0d idle", i), 32'(busy), 32'd0);
         check($sformatf("vec%0d hold", i), result, vecs[i].exp);
      end

      // back-to-back: second start in the IDLE cycle right after FINISH
      do_op(F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "b2b first");
      @(negedge clk);
      do_op(F3_DIV, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFD, "b2b second");
      @(negedge clk);

      // start held high through busy: operands changed after acceptance
      op    = F3_MUL;
      a     = 32'd7;
      b     = 32'hFFFF_FFFD;
      start = 1'b1;
      @(posedge clk);
      k     = 0;
      first = 0;
      ndone = 0;
      held  = '0;
      while (k < 80) begin
         @(negedge clk);
         k++;
         if (k == 1) begin
            a = 32'h1234_5678;
            b = 32'h0000_0055;
         end
         if (done) begin
            ndone++;
            if (first == 0) begin
               first = k;
               held  = result;
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      check("held_start latency", 32'(first), 32'd33);
      check("held_start result", held, 32'hFFFF_FFEB);
      check("held_start done_count", 32'(ndone), 32'd1);
      @(negedge clk);

      // flush in cycle N+10
      op    = F3_DIVU;
      a     = 32'd100;
      b     = 32'd7;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      ndone = 0;
      for (int j = 1; j <= 10; j++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      flush = 1'b1;
      #1 check("flush done_low", 32'(done), 32'd0);
      @(negedge clk);
      check("flush busy_next", 32'(busy), 32'd0);
      check("flush result_kept", result, 32'hFFFF_FFEB);
      flush = 1'b0;
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("flush no_done", 32'(ndone), 32'd0);
      do_op(F3_DIVU, 32'd100, 32'd7, 32'd14, "after_flush");
      @(negedge clk);

      // asynchronous reset in cycle N+5
      op    = F3_MULHU;
      a     = 32'hFFFF_FFFF;
      b     = 32'hFFFF_FFFF;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst busy", 32'(busy), 32'd0);
      check("async_rst done", 32'(done), 32'd0);
      check("async_rst result", result, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      ndone = 0;
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("rst no_done", 32'(ndone), 32'd0);
      do_op(F3_DIV, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFD, "after_rst");
      @(negedge clk);

      // flush beats start in the same IDLE cycle
      op    = F3_MUL;
      a     = 32'd3;
      b     = 32'd3;
      start = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      check("flush_vs_start busy", 32'(busy), 32'd0);
      check("flush_vs_start result", result, 32'hFFFF_FFFD);

      // randomized against the reference model
      for (int i = 0; i < 150; i++) begin
         muldiv_op_e  ro;
         logic [31:0] rx, ry;
         ro = muldiv_op_e'($urandom_range(0, 7));
         rx = pick();
         ry = pick();
         do_op(ro, rx, ry, model(ro, rx, ry), $sformatf("rnd%0d op%0d a=%08h b=%08h", i, ro, rx, ry));
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
